phase_driver: RTL and testbench
===============================

// Module: phase_driver
// PURPOSE
//  Per-phase PWM half-bridge driver for the BLDC motor path; three instances sit under the motor controller, one per phase.
//  Converts a duty-cycle word plus a high-Z (float) request into complementary high/low gate signals.
//  Inserts dead time on every high/low changeover so both switches are never on together.
//  Commutation (hall decode) sits upstream and drives duty_cycle (0 = low side on) and high_z.
// PARAMETERS
//  DEAD_TIME            2      cycles both gates held low at every changeover; values <1 are treated as 1
//  COUNTER_WIDTH        10     width of the free-running PWM period counter
//  MAX_COUNTER          'h3FF  last count of a PWM period (period = MAX_COUNTER+1 clocks)
//  DUTY_CYCLE_WIDTH     10     width of duty_cycle
//  MAX_DUTY_CYCLE       'h3FF  full-scale duty; at or above this value the high side is forced on for the whole period
//  DUTY_CYCLE_STEP_RES  1      counter ticks per duty LSB (cmp = duty*STEP_RES)
// PORTS
//  clk         in   1                 system clock, all logic on rising edge
//  rst         in   1                 asynchronous reset, active-high
//  duty_cycle  in   DUTY_CYCLE_WIDTH  requested high-side on-time per period
//  high_z      in   1                 1 = float the phase (both gates off)
//  pwm_high    out  1                 high-side gate, registered
//  pwm_low     out  1                 low-side gate, registered
// BEHAVIOUR
//  - One clock domain; asynchronous active-high reset. rst forces immediately: cnt=0, cmp=0, state=Z, dt=0, pwm_high=0, pwm_low=0.
//  - cnt: counts 0..MAX_COUNTER, then wraps to 0.
//  - cmp is latched only when cnt==MAX_COUNTER and is used for the whole next period, so a mid-period duty change takes effect at the next cnt=0.
//  - Latched value: duty_cycle >= MAX_DUTY_CYCLE gives cmp = MAX_COUNTER+1 (always high).
//    Otherwise cmp = min(duty_cycle*DUTY_CYCLE_STEP_RES, MAX_COUNTER+1), computed at full width with no overflow.
//  - req = (cnt < cmp). duty 0 gives req always 0, so the low side is on continuously.
//  - FSM states Z, DEAD, HIGH, LOW. high_z=1 in any state goes to Z on the next clock, with priority over every other transition:
//      Z:    both gates off; high_z=0 -> DEAD with dt=0
//      DEAD: both gates off; dt increments; when dt==DEAD_TIME-1 -> HIGH if req, else LOW
//      HIGH: pwm_high=1; !req -> DEAD with dt=0
//      LOW:  pwm_low=1;  req -> DEAD with dt=0
//  - Gate outputs are registered decodes of the next state, so they change one clock after the cause.
//  - Invariant: pwm_high & pwm_low is never 1.
//  - Gate timing at the defaults:
//      leaving Z, both gates stay off for exactly DEAD_TIME cycles;
//      each high/low changeover has exactly DEAD_TIME off cycles;
//      each pulse is shortened by DEAD_TIME.
//  - Reset mid-period: outputs drop asynchronously; after release the behaviour equals power-up.
// CONFIGURATION
//  PHASE_DRIVER_INPUT_SYNC_EN
//  - Defined: duty_cycle and high_z each pass through a 2-flop synchronizer, reset to 0 and 1 respectively, before use.
//    This adds 2 cycles of input latency.
//  - Undefined: inputs are sampled directly. They must then be synchronous to clk.
// TESTING
//  1. rst pulsed while pwm_high=1 -> both outputs 0 within the reset cycle; cnt restarts at 0.
//  2. high_z=0, duty=0 -> both gates off for 2 cycles, then pwm_low=1 continuously; pwm_high is never 1.
//  3. duty=256 steady -> every 1024-cycle period has pwm_high 254 cycles and pwm_low 766 cycles, with two 2-cycle dead gaps.
//  4. duty=0x3FF -> pwm_high stays 1 for entire periods; pwm_low stays 0.
//  5. high_z 0->1 while pwm_high=1 -> both gates 0 next clock.
//     high_z 1->0 -> both gates stay 0 for 2 cycles before either asserts.
//  6. duty changed 256->512 at cnt=100 -> the current period still ends high time at cnt 256; the next period is high through cnt 511.
//     Assert !(pwm_high&pwm_low) on every cycle of every test.

Source files
------------

// File: rtl/phase_driver.sv
// Per-phase PWM half-bridge gate driver with dead-time insertion and high-Z float.
// Optional build macro PHASE_DRIVER_INPUT_SYNC_EN adds 2-flop synchronizers on duty_cycle and high_z.
module phase_driver #(
    parameter int          DEAD_TIME           = 2,
    parameter int unsigned COUNTER_WIDTH       = 10,
    parameter int unsigned MAX_COUNTER         = 'h3FF,
    parameter int unsigned DUTY_CYCLE_WIDTH    = 10,
    parameter int unsigned MAX_DUTY_CYCLE      = 'h3FF,
    parameter int unsigned DUTY_CYCLE_STEP_RES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
    input  logic                        high_z,
    output logic                        pwm_high,
    output logic                        pwm_low
);

    localparam int unsigned DT     = (DEAD_TIME < 1) ? 32'd1 : 32'(DEAD_TIME);
    localparam int unsigned DT_W   = (DT > 1) ? $clog2(DT) : 1;
    localparam int unsigned CMP_W  = COUNTER_WIDTH + 1;
    localparam int unsigned PROD_W = DUTY_CYCLE_WIDTH + 32;

    localparam logic [PROD_W-1:0] FULL_SCALE = PROD_W'(MAX_COUNTER) + PROD_W'(1);

    typedef enum logic [1:0] {
        ST_Z,
        ST_DEAD,
        ST_HIGH,
        ST_LOW
    } state_t;

    logic [DUTY_CYCLE_WIDTH-1:0] duty_s;
    logic                        high_z_s;

`ifdef PHASE_DRIVER_INPUT_SYNC_EN
    logic [DUTY_CYCLE_WIDTH-1:0] duty_meta;
    logic                        high_z_meta;

    // Float request resets to 1 so the bridge stays off until the synchronizer settles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_meta   <= '0;
            duty_s      <= '0;
            high_z_meta <= 1'b1;
            high_z_s    <= 1'b1;
        end else begin
            duty_meta   <= duty_cycle;
            duty_s      <= duty_meta;
            high_z_meta <= high_z;
            high_z_s    <= high_z_meta;
        end
    end
`else
    assign duty_s   = duty_cycle;
    assign high_z_s = high_z;
`endif

    logic [COUNTER_WIDTH-1:0] cnt;
    logic [CMP_W-1:0]         cmp;
    logic [CMP_W-1:0]         cmp_nxt;
    logic [PROD_W-1:0]        prod;
    logic                     cnt_last;
    logic                     req;
    state_t                   state;
    logic [DT_W-1:0]          dt;

    // Compare threshold for the next period, saturated at full scale.
    always_comb begin
        prod    = PROD_W'(duty_s) * PROD_W'(DUTY_CYCLE_STEP_RES);
        cmp_nxt = CMP_W'(prod);
        if ((PROD_W'(duty_s) >= PROD_W'(MAX_DUTY_CYCLE)) || (prod >= FULL_SCALE)) begin
            cmp_nxt = CMP_W'(FULL_SCALE);
        end
    end

    assign cnt_last = (cnt == COUNTER_WIDTH'(MAX_COUNTER));
    assign req      = (CMP_W'(cnt) < cmp);

    // Free-running period counter; threshold only moves at the period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            cmp <= '0;
        end else if (cnt_last) begin
            cnt <= '0;
            cmp <= cmp_nxt;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Gate FSM; outputs are registered decodes of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_Z;
            dt       <= '0;
            pwm_high <= 1'b0;
            pwm_low  <= 1'b0;
        end else begin
            pwm_high <= 1'b0;
            pwm_low  <= 1'b0;
            if (high_z_s) begin
                state <= ST_Z;
            end else begin
                case (state)
                    ST_Z: begin
                        state <= ST_DEAD;
                        dt    <= '0;
                    end
                    ST_DEAD: begin
                        if (dt == DT_W'(DT - 1)) begin
                            if (req) begin
                                state    <= ST_HIGH;
                                pwm_high <= 1'b1;
                            end else begin
                                state   <= ST_LOW;
                                pwm_low <= 1'b1;
                            end
                        end else begin
                            dt <= dt + 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (!req) begin
                            state <= ST_DEAD;
                            dt    <= '0;
                        end else begin
                            pwm_high <= 1'b1;
                        end
                    end
                    ST_LOW: begin
                        if (req) begin
                            state <= ST_DEAD;
                            dt    <= '0;
                        end else begin
                            pwm_low <= 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_Z;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_phase_driver.sv
// Scoreboard bench for phase_driver: expected gate segments (level pair + run length) are queued
// by the stimulus and checked by a monitor each time the gate pair changes.
module tb_phase_driver;

    typedef struct packed {
        logic        h;
        logic        l;
        logic [31:0] len;
    } seg_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] duty_cycle = 10'd0;
    logic       high_z = 1'b1;
    logic       pwm_high;
    logic       pwm_low;

    seg_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   done   = 1'b0;

    phase_driver dut (
        .clk        (clk),
        .rst        (rst),
        .duty_cycle (duty_cycle),
        .high_z     (high_z),
        .pwm_high   (pwm_high),
        .pwm_low    (pwm_low)
    );

    always #5 clk = ~clk;

    task automatic push(input logic h, input logic l, input int unsigned len);
        seg_t s;
        s.h   = h;
        s.l   = l;
        s.len = len;
        exp_q.push_back(s);
    endtask

    // Stimulus; N<k> in comments is the k-th falling edge after the first reset release.
    initial begin
        duty_cycle = 10'd256;
        high_z     = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        push(0, 0, 2);    push(0, 1, 1022);
        push(0, 0, 2);    push(1, 0, 254);
        push(0, 0, 2);    push(0, 1, 766);
        push(0, 0, 2);    push(1, 0, 254);
        push(0, 0, 2);    push(0, 1, 766);
        #2 rst = 1'b0;
        mon_en = 1'b1;
        repeat (2148) @(negedge clk);           // N2148, cnt=100
        duty_cycle = 10'd512;
        push(0, 0, 2);    push(1, 0, 510);
        push(0, 0, 2);    push(0, 1, 510);
        repeat (1052) @(negedge clk);           // N3200
        duty_cycle = 10'h3FF;
        push(0, 0, 2);
        repeat (2000) @(negedge clk);           // N5200, high side on
        high_z = 1'b1;
        push(1, 0, 1102);
        repeat (10) @(negedge clk);             // N5210
        high_z = 1'b0;
        push(0, 0, 12);
        repeat (90) @(negedge clk);             // N5300, high side on
        push(1, 0, 88);
        #2 rst = 1'b1;
        repeat (5) @(negedge clk);              // N5305
        push(0, 0, 7);    push(0, 1, 1022);     push(0, 0, 2);
        #2 rst = 1'b0;
        repeat (1095) @(negedge clk);           // N6400
        duty_cycle = 10'd0;
        push(1, 0, 1022); push(0, 0, 2);
        repeat (2100) @(negedge clk);           // N8500
        high_z = 1'b1;
        push(0, 1, 1145);
        repeat (5) @(negedge clk);
        #2 done = 1'b1;
    end

    // Monitor: reset response, overlap invariant, segment scoreboard, final drain.
    logic        ph;
    logic        pl;
    int unsigned run;
    bit          have_prev = 1'b0;
    logic        rst_q = 1'b0;
    int          seg_idx = 0;
    seg_t        e;

    always begin
        @(negedge clk or posedge rst);
        if (rst && !rst_q) begin
            rst_q = 1'b1;
            #1;
            checks++;
            if (pwm_high !== 1'b0 || pwm_low !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs got high=%b low=%b required high=0 low=0", pwm_high, pwm_low);
            end
        end else begin
            rst_q = rst;
            if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL drain got %0d segments left required 0", exp_q.size());
                end
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end else if (mon_en) begin
                checks++;
                assert (!(pwm_high && pwm_low)) else begin
                    errors++;
                    $display("FAIL overlap at %0t got high=%b low=%b required not both 1", $time, pwm_high, pwm_low);
                end
                if (!have_prev) begin
                    have_prev = 1'b1;
                    ph  = pwm_high;
                    pl  = pwm_low;
                    run = 1;
                end else if (pwm_high === ph && pwm_low === pl) begin
                    run++;
                end else begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL seg%0d got high=%b low=%b len=%0d required no further segment",
                                 seg_idx, ph, pl, run);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.h !== ph || e.l !== pl || e.len != run) begin
                            errors++;
                            $display("FAIL seg%0d got high=%b low=%b len=%0d required high=%b low=%b len=%0d",
                                     seg_idx, ph, pl, run, e.h, e.l, e.len);
                        end
                    end
                    seg_idx++;
                    ph  = pwm_high;
                    pl  = pwm_low;
                    run = 1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "timeout");
    end

endmodule
